// File: rtl/multi_timer.sv
// multi_timer: CHANNELS independent programmable tick generators.
// Each channel divides the clock by its own period and emits a one-cycle tick
// at terminal count, in periodic or one-shot mode, with a per-channel pause.
module multi_timer #(
   parameter int unsigned CHANNELS       = 4,
   parameter int unsigned WIDTH          = 32,
   parameter int unsigned DEFAULT_PERIOD = 5,
   parameter int unsigned CH_W           = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                clock,
   input  logic                rst,
   input  logic                load,
   input  logic [CH_W-1:0]     load_ch,
   input  logic [WIDTH-1:0]    load_period,
   input  logic                load_oneshot,
   input  logic [CHANNELS-1:0] enable,
   output logic [CHANNELS-1:0] tick,
   output logic [CHANNELS-1:0] done
);

   typedef enum logic {StRun, StStop} state_e;

   localparam logic [WIDTH-1:0] ResetPeriod = WIDTH'(DEFAULT_PERIOD);
   localparam logic [WIDTH-1:0] One         = WIDTH'(1);

   // One-hot load decode; an index >= CHANNELS matches no channel and is ignored.
   logic [CHANNELS-1:0] w_load_hit;

   // Decode the load strobe into a per-channel write enable.
   always_comb begin
      w_load_hit = '0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
         if (load && (load_ch == CH_W'(i))) begin
            w_load_hit[i] = 1'b1;
         end
      end
   end

   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      state_e           r_state;
      state_e           w_state_nxt;
      logic [WIDTH-1:0] r_period;
      logic [WIDTH-1:0] w_period_nxt;
      logic [WIDTH-1:0] r_count;
      logic [WIDTH-1:0] w_count_nxt;
      logic             r_oneshot;
      logic             w_oneshot_nxt;
      logic             r_tick;
      logic             w_tick_nxt;
      logic             r_done;
      logic             w_done_nxt;
      logic             w_terminal;

      // Counter never exceeds period-1, so the subtraction cannot wrap when period != 0.
      assign w_terminal = (r_period != '0) && (r_count == (r_period - One));

      // Next-state: a load wins over everything except reset, including a terminal count.
      always_comb begin
         w_state_nxt   = r_state;
         w_period_nxt  = r_period;
         w_count_nxt   = r_count;
         w_oneshot_nxt = r_oneshot;
         w_done_nxt    = r_done;
         w_tick_nxt    = 1'b0;
         if (w_load_hit[g]) begin
            w_period_nxt  = load_period;
            w_oneshot_nxt = load_oneshot;
            w_count_nxt   = '0;
            w_state_nxt   = StRun;
            w_done_nxt    = 1'b0;
         end else begin
            unique case (r_state)
               StRun: begin
                  // Paused or zero-period channels simply hold their count.
                  if (enable[g] && (r_period != '0)) begin
                     if (w_terminal) begin
                        w_count_nxt = '0;
                        w_tick_nxt  = 1'b1;
                        if (r_oneshot) begin
                           w_state_nxt = StStop;
                           w_done_nxt  = 1'b1;
                        end
                     end else begin
                        w_count_nxt = r_count + One;
                     end
                  end
               end
               StStop: begin
                  w_count_nxt = '0;
               end
               default: begin
                  w_state_nxt = StRun;
               end
            endcase
         end
      end

      // Channel state register with synchronous reset to the legacy free-running timer.
      always_ff @(posedge clock) begin
         if (rst) begin
            r_state   <= StRun;
            r_period  <= ResetPeriod;
            r_count   <= '0;
            r_oneshot <= 1'b0;
            r_tick    <= 1'b0;
            r_done    <= 1'b0;
         end else begin
            r_state   <= w_state_nxt;
            r_period  <= w_period_nxt;
            r_count   <= w_count_nxt;
            r_oneshot <= w_oneshot_nxt;
            r_tick    <= w_tick_nxt;
            r_done    <= w_done_nxt;
         end
      end

      assign tick[g] = r_tick;
      assign done[g] = r_done;
   end

endmodule

// File: tb/tb_multi_timer.sv
// tb_multi_timer: directed + random stimulus, countdown reference model,
// expected outputs queued per cycle and checked by an independent monitor.
module tb_multi_timer;

   localparam int unsigned CH  = 5;
   localparam int unsigned W   = 8;
   localparam int unsigned DEF = 5;
   localparam int unsigned CHW = 3;

   bit             clock;
   logic           rst;
   logic           load;
   logic [CHW-1:0] load_ch;
   logic [W-1:0]   load_period;
   logic           load_oneshot;
   logic [CH-1:0]  enable;
   logic [CH-1:0]  tick;
   logic [CH-1:0]  done;

   multi_timer #(
      .CHANNELS       (CH),
      .WIDTH          (W),
      .DEFAULT_PERIOD (DEF)
   ) dut (
      .clock        (clock),
      .rst          (rst),
      .load         (load),
      .load_ch      (load_ch),
      .load_period  (load_period),
      .load_oneshot (load_oneshot),
      .enable       (enable),
      .tick         (tick),
      .done         (done)
   );

   always #5 clock = ~clock;

   logic [2*CH-1:0] exp_q[$];
   int n_vec = 0;
   int n_err = 0;

   // Reference model: cycles remaining until the next tick, per channel.
   int m_per  [CH];
   int m_rem  [CH];
   bit m_one  [CH];
   bit m_stop [CH];
   bit m_done [CH];

   // Predict the outputs after the coming edge, queue them, then take the edge.
   task automatic cycle();
      logic [CH-1:0] et;
      logic [CH-1:0] ed;
      et = '0;
      ed = '0;
      for (int i = 0; i < int'(CH); i++) begin
         if (rst) begin
            m_per[i]  = int'(DEF);
            m_rem[i]  = int'(DEF);
            m_one[i]  = 1'b0;
            m_stop[i] = 1'b0;
            m_done[i] = 1'b0;
         end else if (load && (int'(load_ch) == i)) begin
            m_per[i]  = int'(load_period);
            m_rem[i]  = int'(load_period);
            m_one[i]  = load_oneshot;
            m_stop[i] = 1'b0;
            m_done[i] = 1'b0;
         end else if (!m_stop[i] && enable[i] && (m_per[i] != 0)) begin
            m_rem[i] = m_rem[i] - 1;
            if (m_rem[i] == 0) begin
               et[i] = 1'b1;
               if (m_one[i]) begin
                  m_stop[i] = 1'b1;
                  m_done[i] = 1'b1;
               end else begin
                  m_rem[i] = m_per[i];
               end
            end
         end
         ed[i] = m_done[i];
      end
      exp_q.push_back({et, ed});
      @(posedge clock);
      #1;
   endtask

   task automatic run(input int n);
      repeat (n) cycle();
   endtask

   task automatic do_load(input int ch, input int p, input bit os);
      load         = 1'b1;
      load_ch      = CHW'(ch);
      load_period  = W'(p);
      load_oneshot = os;
      cycle();
      load = 1'b0;
   endtask

   // Monitor: compare DUT outputs against the oldest queued expectation.
   always @(negedge clock) begin
      logic [2*CH-1:0] e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_vec++;
         if ({tick, done} !== e) begin
            n_err++;
            $display("FAIL tick_done vec %0d: got tick=%b done=%b, want tick=%b done=%b",
                     n_vec, tick, done, e[2*CH-1:CH], e[CH-1:0]);
         end
      end
   end

   initial begin
      rst          = 1'b1;
      load         = 1'b0;
      load_ch      = '0;
      load_period  = '0;
      load_oneshot = 1'b0;
      enable       = '1;
      run(3);
      rst = 1'b0;
      run(16);
      // ch2 periodic P=3 while others keep the default cadence
      do_load(2, 3, 0);
      run(12);
      // ch1 one-shot P=4, then reload clears done
      do_load(1, 4, 1);
      run(24);
      do_load(1, 4, 0);
      run(3);
      // ch0 pause for 7 cycles after count 2
      do_load(0, 5, 0);
      run(2);
      enable[0] = 1'b0;
      run(7);
      enable[0] = 1'b1;
      run(12);
      // P=1, P=0, out-of-range channel indices
      do_load(3, 1, 0);
      run(5);
      do_load(3, 0, 0);
      run(10);
      do_load(5, 2, 1);
      run(3);
      do_load(7, 9, 1);
      run(3);
      // load on the terminal-count edge
      do_load(4, 3, 0);
      run(2);
      do_load(4, 3, 0);
      run(8);
      // reset mid-count
      run(2);
      rst = 1'b1;
      run(1);
      rst = 1'b0;
      run(12);
      // maximum period
      do_load(2, 255, 0);
      run(520);
      // random phase
      repeat (2000) begin
         rst = ($urandom_range(0, 199) == 0);
         for (int i = 0; i < int'(CH); i++) enable[i] = ($urandom_range(0, 7) != 0);
         if ($urandom_range(0, 5) == 0) begin
            load         = 1'b1;
            load_ch      = CHW'($urandom_range(0, 7));
            load_period  = ($urandom_range(0, 29) == 0) ? W'($urandom_range(100, 255))
                                                        : W'($urandom_range(0, 12));
            load_oneshot = 1'($urandom_range(0, 1));
         end else begin
            load = 1'b0;
         end
         cycle();
      end
      rst  = 1'b0;
      load = 1'b0;
      // drain the scoreboard with a bounded wait
      for (int k = 0; (k < 10) && (exp_q.size() != 0); k++) begin
         @(negedge clock);
         #1;
      end
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
